// File: rtl/op_sequencer.sv
// rtl/op_sequencer.sv - instruction queue that issues ops to the calculator FSM over a four-phase PERFORM/EXEC_DONE handshake
module op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       PUSH,
  input  logic [2:0] PUSH_OP,
  input  logic [1:0] PUSH_K,
  input  logic       CLEAR,
  input  logic       HALT,
  input  logic       EXEC_DONE,
  output logic [2:0] EXEC_OP,
  output logic [1:0] EXEC_K,
  output logic       PERFORM,
  output logic [3:0] COUNT,
  output logic       EMPTY,
  output logic       FULL,
  output logic       BUSY,
  output logic [7:0] RETIRED,
  output logic       DROP,
  output logic       TIMEOUT_ERR
);

  localparam int         AW         = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C    = 4'(DEPTH);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RECOVER} state_t;

  state_t        state, state_next;
  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    count;
  logic [7:0]    timer;
  logic          issue, retire, expire;
  logic          push_ok, push_drop;

  assign COUNT   = count;
  assign EMPTY   = (count == 4'd0);
  assign FULL    = (count == DEPTH_C);
  assign PERFORM = (state == ACTIVE);
  assign BUSY    = (state != IDLE);

  // A full queue rejects the push even if the head pops on the same edge.
  assign push_ok   = PUSH && !FULL && !CLEAR;
  assign push_drop = PUSH && FULL && !CLEAR;

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    retire     = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (!EMPTY && !HALT && !EXEC_DONE && !CLEAR) begin
          issue      = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (EXEC_DONE) begin
          retire     = 1'b1;
          state_next = RECOVER;
        end else if (timer == TIMER_LAST) begin
          expire     = 1'b1;
          state_next = RECOVER;
        end
      end
      RECOVER: begin
        if (!EXEC_DONE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET && push_ok) mem[wr_ptr] <= {PUSH_OP, PUSH_K};
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= 4'd0;
      timer       <= 8'd0;
      EXEC_OP     <= 3'd0;
      EXEC_K      <= 2'd0;
      RETIRED     <= 8'd0;
      DROP        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      if (CLEAR) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= 4'd0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (issue)   rd_ptr <= rd_ptr + AW'(1);
        count <= count + 4'(push_ok) - 4'(issue);
      end

      if (issue) {EXEC_OP, EXEC_K} <= mem[rd_ptr];

      // Timer counts ACTIVE edges without DONE; it rests at zero otherwise.
      if (state == ACTIVE && !EXEC_DONE && !expire) timer <= timer + 8'd1;
      else                                          timer <= 8'd0;

      RETIRED <= RETIRED + 8'(retire);

      if (CLEAR)          DROP <= 1'b0;
      else if (push_drop) DROP <= 1'b1;

      if (CLEAR)       TIMEOUT_ERR <= 1'b0;
      else if (expire) TIMEOUT_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// tb/tb_op_sequencer.sv - randomized and directed checks of op_sequencer against a queue-based reference model
module tb_op_sequencer;

  localparam int DEPTH = 4;
  localparam int TO    = 15;

  logic       CLOCK = 1'b0;
  logic       RESET, PUSH, CLEAR, HALT, EXEC_DONE;
  logic [2:0] PUSH_OP;
  logic [1:0] PUSH_K;
  logic [2:0] EXEC_OP;
  logic [1:0] EXEC_K;
  logic       PERFORM, EMPTY, FULL, BUSY, DROP, TIMEOUT_ERR;
  logic [3:0] COUNT;
  logic [7:0] RETIRED;

  op_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .PUSH(PUSH), .PUSH_OP(PUSH_OP), .PUSH_K(PUSH_K),
    .CLEAR(CLEAR), .HALT(HALT), .EXEC_DONE(EXEC_DONE), .EXEC_OP(EXEC_OP), .EXEC_K(EXEC_K),
    .PERFORM(PERFORM), .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL), .BUSY(BUSY),
    .RETIRED(RETIRED), .DROP(DROP), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  int n_vec = 0;
  int n_err = 0;

  task automatic expect_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of {op,k}, instruction phase (0 idle, 1 in flight, 2 waiting for DONE low)
  int mq[$];
  int m_phase, m_age, m_op, m_k, m_ret;
  bit m_drop, m_terr;
  int issued[$];

  task automatic model_edge();
    bit was_full, expired;
    int e;
    if (RESET) begin
      mq.delete();
      m_phase = 0; m_age = 0; m_op = 0; m_k = 0; m_ret = 0; m_drop = 0; m_terr = 0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    expired  = 0;
    if (m_phase == 0) begin
      if (mq.size() != 0 && !HALT && !EXEC_DONE && !CLEAR) begin
        e = mq.pop_front();
        m_op = e / 4; m_k = e % 4; m_phase = 1; m_age = 0;
      end
    end else if (m_phase == 1) begin
      if (EXEC_DONE) begin
        m_ret = (m_ret + 1) % 256; m_phase = 2;
      end else begin
        m_age++;
        if (m_age == TO) begin expired = 1; m_phase = 2; end
      end
    end else if (!EXEC_DONE) begin
      m_phase = 0;
    end
    if (CLEAR) begin
      mq.delete(); m_drop = 0; m_terr = 0;
    end else begin
      if (PUSH) begin
        if (was_full) m_drop = 1;
        else          mq.push_back(int'(PUSH_OP) * 4 + int'(PUSH_K));
      end
      if (expired) m_terr = 1;
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    model_edge();
    #1;
    expect_eq("perform", int'(PERFORM), int'(m_phase == 1));
    expect_eq("exec_op", int'(EXEC_OP), m_op);
    expect_eq("exec_k", int'(EXEC_K), m_k);
    expect_eq("count", int'(COUNT), mq.size());
    expect_eq("empty", int'(EMPTY), int'(mq.size() == 0));
    expect_eq("full", int'(FULL), int'(mq.size() == DEPTH));
    expect_eq("busy", int'(BUSY), int'(m_phase != 0));
    expect_eq("retired", int'(RETIRED), m_ret);
    expect_eq("drop", int'(DROP), int'(m_drop));
    expect_eq("timeout_err", int'(TIMEOUT_ERR), int'(m_terr));
  endtask

  task automatic do_reset();
    RESET = 1; PUSH = 0; CLEAR = 0; HALT = 0; EXEC_DONE = 0; PUSH_OP = 0; PUSH_K = 0;
    step();
    RESET = 0;
  endtask

  task automatic push_one(input int op, input int k);
    PUSH = 1; PUSH_OP = 3'(op); PUSH_K = 2'(k);
    step();
    PUSH = 0;
  endtask

  // Calculator stand-in: raises DONE after lat edges of PERFORM, drops it once PERFORM falls
  task automatic drain(input int lat);
    int guard = 0;
    int cnt = 0;
    bit prev = PERFORM;
    while (!(EMPTY && !BUSY) && guard < 500) begin
      if (PERFORM) begin
        if (cnt >= lat) EXEC_DONE = 1;
        cnt++;
      end else begin
        EXEC_DONE = 0; cnt = 0;
      end
      step();
      if (PERFORM && !prev) issued.push_back(int'(EXEC_OP));
      prev = PERFORM;
      guard++;
    end
    EXEC_DONE = 0;
    expect_eq("drain_bound", int'(guard < 500), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, g, lat;
    bit stuck;
    RESET = 1; PUSH = 0; CLEAR = 0; HALT = 0; EXEC_DONE = 0; PUSH_OP = 0; PUSH_K = 0;

    do_reset();
    expect_eq("rst_perform", int'(PERFORM), 0);
    expect_eq("rst_count", int'(COUNT), 0);
    expect_eq("rst_empty", int'(EMPTY), 1);
    expect_eq("rst_busy", int'(BUSY), 0);
    expect_eq("rst_exec_op", int'(EXEC_OP), 0);

    // Single instruction: minimum latency and four PERFORM edges with DONE on the fourth
    push_one(4, 2);
    step();
    expect_eq("lat_perform", int'(PERFORM), 1);
    expect_eq("lat_op", int'(EXEC_OP), 4);
    expect_eq("lat_k", int'(EXEC_K), 2);
    hi = 0;
    while (PERFORM && hi < 20) begin
      if (hi == 3) EXEC_DONE = 1;
      step();
      hi++;
    end
    expect_eq("perform_edges", hi, 4);
    expect_eq("retired_one", int'(RETIRED), 1);
    expect_eq("busy_recover", int'(BUSY), 1);
    EXEC_DONE = 0;
    step();
    expect_eq("busy_after_done_low", int'(BUSY), 0);

    // Overfill under HALT, then FIFO order on release
    do_reset();
    HALT = 1;
    for (int i = 0; i < 5; i++) push_one(i, i % 4);
    expect_eq("fill_count", int'(COUNT), 4);
    expect_eq("fill_full", int'(FULL), 1);
    expect_eq("fill_drop", int'(DROP), 1);
    HALT = 0;
    issued.delete();
    drain(1);
    expect_eq("order_len", issued.size(), 4);
    for (int i = 0; i < 4 && i < issued.size(); i++) expect_eq("order_op", issued[i], i);
    expect_eq("order_retired", int'(RETIRED), 4);
    expect_eq("order_empty", int'(EMPTY), 1);

    // CLEAR with PUSH on a full queue: clear wins, no drop
    do_reset();
    HALT = 1;
    for (int i = 0; i < 4; i++) push_one(7 - i, i);
    PUSH = 1; CLEAR = 1;
    step();
    PUSH = 0; CLEAR = 0; HALT = 0;
    expect_eq("clear_push_count", int'(COUNT), 0);
    expect_eq("clear_push_drop", int'(DROP), 0);

    // Timeout with DONE stuck low, following entry still issues, CLEAR clears the flag
    do_reset();
    push_one(6, 1);
    push_one(3, 0);
    hi = 0;
    while (PERFORM && hi < 40) begin
      step();
      hi++;
    end
    expect_eq("timeout_edges", hi, TO);
    expect_eq("timeout_flag", int'(TIMEOUT_ERR), 1);
    expect_eq("timeout_retired", int'(RETIRED), 0);
    g = 0;
    while (!PERFORM && g < 10) begin
      step();
      g++;
    end
    expect_eq("after_timeout_op", int'(EXEC_OP), 3);
    CLEAR = 1;
    step();
    CLEAR = 0;
    expect_eq("clear_timeout_flag", int'(TIMEOUT_ERR), 0);
    expect_eq("clear_keeps_active", int'(PERFORM), 1);
    drain(0);

    // DONE high from reset blocks issue until it falls
    do_reset();
    EXEC_DONE = 1;
    push_one(5, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_eq("done_high_no_issue", int'(PERFORM), 0);
    end
    EXEC_DONE = 0;
    step();
    expect_eq("issue_after_done_low", int'(PERFORM), 1);
    expect_eq("issue_after_done_op", int'(EXEC_OP), 5);
    drain(2);

    // Reset mid-instruction with three queued entries
    do_reset();
    for (int i = 0; i < 4; i++) push_one(i + 1, 3);
    expect_eq("pre_rst_count", int'(COUNT), 3);
    expect_eq("pre_rst_perform", int'(PERFORM), 1);
    RESET = 1; PUSH = 1; EXEC_DONE = 1;
    step();
    RESET = 0; PUSH = 0; EXEC_DONE = 0;
    expect_eq("mid_rst_perform", int'(PERFORM), 0);
    expect_eq("mid_rst_count", int'(COUNT), 0);
    expect_eq("mid_rst_retired", int'(RETIRED), 0);
    expect_eq("mid_rst_flags", int'({DROP, TIMEOUT_ERR, BUSY}), 0);

    // RETIRED wrap at 255 -> 0
    do_reset();
    g = 0;
    while (m_ret != 255 && g < 3000) begin
      PUSH = (mq.size() < 3); PUSH_OP = 3'($urandom); PUSH_K = 2'($urandom);
      EXEC_DONE = PERFORM;
      step();
      g++;
    end
    expect_eq("ret255_bound", int'(g < 3000), 1);
    expect_eq("ret255", int'(RETIRED), 255);
    g = 0;
    while (m_ret == 255 && g < 50) begin
      PUSH = (mq.size() < 3); PUSH_OP = 3'($urandom); PUSH_K = 2'($urandom);
      EXEC_DONE = PERFORM;
      step();
      g++;
    end
    PUSH = 0; EXEC_DONE = 0;
    expect_eq("ret_wrap", int'(RETIRED), 0);

    // Push and issue on the same edge at COUNT=2
    do_reset();
    HALT = 1;
    push_one(1, 1);
    push_one(2, 2);
    HALT = 0;
    push_one(3, 3);
    expect_eq("push_issue_count", int'(COUNT), 2);
    expect_eq("push_issue_perform", int'(PERFORM), 1);
    expect_eq("push_issue_op", int'(EXEC_OP), 1);
    drain(0);

    // Randomized traffic against the model
    do_reset();
    lat = 0; stuck = 0;
    for (int c = 0; c < 4000; c++) begin
      RESET   = ($urandom_range(0, 399) == 0);
      PUSH    = ($urandom_range(0, 2) == 0);
      PUSH_OP = 3'($urandom);
      PUSH_K  = 2'($urandom);
      CLEAR   = ($urandom_range(0, 49) == 0);
      HALT    = ($urandom_range(0, 7) == 0);
      if (PERFORM) begin
        if (!EXEC_DONE && !stuck) begin
          if (lat == 0) EXEC_DONE = 1;
          else          lat--;
        end
      end else begin
        if (EXEC_DONE && $urandom_range(0, 2) == 0)       EXEC_DONE = 0;
        else if (!EXEC_DONE && $urandom_range(0, 60) == 0) EXEC_DONE = 1;
        lat   = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 16) : $urandom_range(0, 5);
        stuck = ($urandom_range(0, 7) == 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
